qdr_multiport_sniffer: RTL

- N-port successor to the single-slave QDR sniffer: merges NUM_PORTS fabric request ports onto one QDR controller master port.
- Arbitration is fixed-priority or round-robin.
- Read returns are routed back to the issuing port through a tag FIFO.
- Holds issue until phy_rdy; keeps sticky per-port overflow flags and an orphan-read counter for debug.

---
 rtl/qdr_multiport_sniffer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/qdr_multiport_sniffer.sv
// N-port QDR request merger with fixed-priority or round-robin arbitration.
// Read returns are steered back to their port through a tag FIFO.
module qdr_multiport_sniffer #(
  parameter int NUM_PORTS      = 4,
  parameter int QDR_ADDR_WIDTH = 21,
  parameter int QDR_DATA_WIDTH = 36,
  parameter int QDR_BW_WIDTH   = 4,
  parameter int QDR_LATENCY    = 10,
  parameter int ARB_MODE       = 0,
  parameter int TAG_DEPTH      = 16
) (
  input  logic                            qdr_clk,
  input  logic                            qdr_rst,
  input  logic [NUM_PORTS*32-1:0]         slave_addr,
  input  logic [NUM_PORTS-1:0]            slave_wr_strb,
  input  logic [NUM_PORTS*2*QDR_DATA_WIDTH-1:0] slave_wr_data,
  input  logic [NUM_PORTS*2*QDR_BW_WIDTH-1:0]   slave_wr_be,
  input  logic [NUM_PORTS-1:0]            slave_rd_strb,
  output logic [2*QDR_DATA_WIDTH-1:0]     slave_rd_data,
  output logic [NUM_PORTS-1:0]            slave_rd_dvld,
  output logic [NUM_PORTS-1:0]            slave_ack,
  output logic [QDR_ADDR_WIDTH-1:0]       master_addr,
  output logic                            master_wr_strb,
  output logic [2*QDR_DATA_WIDTH-1:0]     master_wr_data,
  output logic [2*QDR_BW_WIDTH-1:0]       master_wr_be,
  output logic                            master_rd_strb,
  input  logic [2*QDR_DATA_WIDTH-1:0]     master_rd_data,
  input  logic                            master_rd_dvld,
  input  logic                            phy_rdy,
  output logic [NUM_PORTS-1:0]            overflow,
  output logic [7:0]                      orphan_cnt
);

  localparam int AW = QDR_ADDR_WIDTH;
  localparam int DW = 2 * QDR_DATA_WIDTH;
  localparam int BW = 2 * QDR_BW_WIDTH;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int TW = $clog2(TAG_DEPTH);

  logic [NUM_PORTS-1:0] pend_vld;
  logic [NUM_PORTS-1:0] pend_rnw;
  logic [AW-1:0]        pend_addr [NUM_PORTS];
  logic [DW-1:0]        pend_data [NUM_PORTS];
  logic [BW-1:0]        pend_be   [NUM_PORTS];

  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        cand;
  logic [PW-1:0]        win_idx;
  logic                 win_vld;
  logic                 win_rnw;
  logic                 issue;
  logic [NUM_PORTS-1:0] issue_oh;

  logic [PW-1:0]        tag_mem [TAG_DEPTH];
  logic [TW-1:0]        tag_wr_ptr;
  logic [TW-1:0]        tag_rd_ptr;
  logic [TW:0]          tag_cnt;
  logic                 tag_full;
  logic                 tag_empty;
  logic                 tag_push;
  logic                 tag_pop;

  function automatic logic [PW-1:0] rr_off(
    input logic [PW-1:0] base,
    input int            off
  );
    int s;
    s = int'(base) + off;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return PW'(s);
  endfunction

  // A full pending slot drops any new strobe; wr wins over rd.
  always_ff @(posedge qdr_clk) begin
    if (qdr_rst) begin
      pend_vld <= '0;
      pend_rnw <= '0;
      overflow <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (pend_vld[p]) begin
          if (slave_wr_strb[p] || slave_rd_strb[p])
            overflow[p] <= 1'b1;
          if (issue_oh[p])
            pend_vld[p] <= 1'b0;
        end else if (slave_wr_strb[p] || slave_rd_strb[p]) begin
          pend_vld[p] <= 1'b1;
          pend_rnw[p] <= !slave_wr_strb[p];
          if (slave_wr_strb[p] && slave_rd_strb[p])
            overflow[p] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge qdr_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!pend_vld[p] && (slave_wr_strb[p] || slave_rd_strb[p])) begin
        pend_addr[p] <= slave_addr[32*p +: AW];
        pend_data[p] <= slave_wr_data[DW*p +: DW];
        pend_be[p]   <= slave_wr_be[BW*p +: BW];
      end
    end
  end

  always_comb begin
    cand    = '0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (ARB_MODE == 0) cand = PW'(i);
      else               cand = rr_off(rr_ptr, i + 1);
      if (!win_vld && pend_vld[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_rnw = pend_rnw[win_idx];
  assign issue   = win_vld && phy_rdy && !(win_rnw && tag_full);

  always_comb begin
    issue_oh = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      issue_oh[p] = issue && (win_idx == PW'(p));
  end

  always_ff @(posedge qdr_clk) begin
    if (qdr_rst) begin
      master_addr    <= '0;
      master_wr_strb <= 1'b0;
      master_rd_strb <= 1'b0;
      master_wr_data <= '0;
      master_wr_be   <= '0;
      slave_ack      <= '0;
      rr_ptr         <= PW'(NUM_PORTS - 1);
    end else begin
      master_wr_strb <= issue && !win_rnw;
      master_rd_strb <= issue && win_rnw;
      slave_ack      <= issue_oh;
      if (issue) begin
        master_addr    <= pend_addr[win_idx];
        master_wr_data <= pend_data[win_idx];
        master_wr_be   <= pend_be[win_idx];
        rr_ptr         <= win_idx;
      end
    end
  end

  assign tag_full  = (tag_cnt == (TW+1)'(TAG_DEPTH));
  assign tag_empty = (tag_cnt == '0);
  assign tag_push  = issue && win_rnw;
  assign tag_pop   = master_rd_dvld && !tag_empty;

  always_ff @(posedge qdr_clk) begin
    if (qdr_rst) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_cnt    <= '0;
    end else begin
      if (tag_push) tag_wr_ptr <= tag_wr_ptr + 1'b1;
      if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + 1'b1;
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  always_ff @(posedge qdr_clk) begin
    if (tag_push) tag_mem[tag_wr_ptr] <= win_idx;
  end

  // Returns with no outstanding tag are counted, never forwarded.
  always_ff @(posedge qdr_clk) begin
    if (qdr_rst) begin
      slave_rd_dvld <= '0;
      slave_rd_data <= '0;
      orphan_cnt    <= '0;
    end else begin
      slave_rd_dvld <= tag_pop ?
        (NUM_PORTS'(1) << tag_mem[tag_rd_ptr]) : '0;
      if (tag_pop) slave_rd_data <= master_rd_data;
      if (master_rd_dvld && tag_empty && orphan_cnt != 8'hFF)
        orphan_cnt <= orphan_cnt + 8'd1;
    end
  end

endmodule
